wb_sram_bridge: RTL and testbench

//  Wishbone classic slave bridging router packets to a single-port synchronous SRAM.

---
 rtl/wb_sram_bridge.sv | 186 ++++++++++++++++++
 tb/tb_wb_sram_bridge.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_sram_bridge.sv
// rtl/wb_sram_bridge.sv - Wishbone classic slave bridging router packets to a single-port sync SRAM
//
// Packet layout on wbs_dat_i / wbs_dat_o: [31:24] CMD | [23:16] DATA | [15:0] COORD.
// Optional feature macro: WB_SRAM_ERR_EN (adds wbs_err_o, flags bad commands / out-of-range addresses).
//
// Ports:
//   clk, rst          clock (posedge) and synchronous active-high reset
//   wbs_adr_i [31:0]  request address, low ADDR_W bits select the SRAM word
//   wbs_dat_i [31:0]  request packet
//   wbs_we_i          1 = write cycle, 0 = read cycle
//   wbs_stb_i         strobe
//   wbs_cyc_i         bus cycle
//   wbs_ack_o         one-cycle acknowledge
//   wbs_dat_o [31:0]  read return packet, valid with the read ack, held until the next read ack
//   sram_addr         SRAM address (held between accesses)
//   sram_din          SRAM write data (held between accesses)
//   sram_dout         SRAM read data, RD_LAT cycles after the address is presented
//   sram_we           SRAM write enable, one-cycle pulse
//   wbs_err_o         one-cycle error pulse (WB_SRAM_ERR_EN builds only)

module wb_sram_bridge #(
    parameter int         ADDR_W = 9,
    parameter int         DATA_W = 8,
    parameter int         RD_LAT = 1,
    parameter logic [7:0] CMD_WR = 8'hA1,
    parameter logic [7:0] CMD_RD = 8'hA2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       wbs_adr_i,
    input  logic [31:0]       wbs_dat_i,
    input  logic              wbs_we_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_cyc_i,
    output logic              wbs_ack_o,
    output logic [31:0]       wbs_dat_o,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_din,
    input  logic [DATA_W-1:0] sram_dout,
`ifdef WB_SRAM_ERR_EN
    output logic              sram_we,
    output logic              wbs_err_o
`else
    output logic              sram_we
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,     // write pulse + ack cycle
        S_RD,     // address presented, waiting out the SRAM latency
        S_RACK,   // read data captured, ack cycle
        S_BAD     // undecodable request, ack/err cycle, no SRAM access
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [2:0]          r_cnt;
    logic [15:0]         r_coord;
    logic [31:0]         r_dat_o;
    logic [ADDR_W-1:0]   r_sram_addr;
    logic [DATA_W-1:0]   r_sram_din;

    logic                w_accept;
    logic                w_adr_ok;
    logic                w_is_wr;
    logic                w_is_rd;
    logic                w_ack;
    logic [7:0]          w_cmd;
    logic [7:0]          w_rd_byte;
    logic                w_unused_bits;
`ifdef WB_SRAM_ERR_EN
    logic                w_err;
`endif

    // Only part of the address/packet reaches the datapath in some configurations.
    assign w_unused_bits = ^{wbs_adr_i, wbs_dat_i};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_ack       = 1'b0;
`ifdef WB_SRAM_ERR_EN
        w_err       = 1'b0;
        w_adr_ok    = ((wbs_adr_i >> ADDR_W) == 32'd0);
`else
        w_adr_ok    = 1'b1;
`endif
        w_cmd       = wbs_dat_i[31:24];
        w_is_wr     = wbs_we_i && (w_cmd == CMD_WR) && w_adr_ok;
        w_is_rd     = !wbs_we_i && (w_cmd == CMD_RD) && w_adr_ok;

        // Return byte is the SRAM word zero-extended to 8 bits.
        w_rd_byte                = '0;
        w_rd_byte[DATA_W-1:0]    = sram_dout;

        case (r_state)
            S_IDLE: begin
                // ack is never asserted while idle, so stb&cyc alone gates acceptance.
                w_accept = wbs_stb_i && wbs_cyc_i;
                if (w_accept) begin
                    if (w_is_wr) begin
                        w_state_nxt = S_WR;
                    end else if (w_is_rd) begin
                        w_state_nxt = S_RD;
                    end else begin
                        w_state_nxt = S_BAD;
                    end
                end
            end
            S_WR: begin
                // The write pulse is unconditional; only the ack follows cyc.
                w_ack       = wbs_cyc_i;
                w_state_nxt = S_IDLE;
            end
            S_RD: begin
                if (!wbs_cyc_i) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == 3'(RD_LAT)) begin
                    w_state_nxt = S_RACK;
                end
            end
            S_RACK: begin
                w_ack       = wbs_cyc_i;
                w_state_nxt = S_IDLE;
            end
            S_BAD: begin
`ifdef WB_SRAM_ERR_EN
                w_err       = wbs_cyc_i;
`else
                w_ack       = wbs_cyc_i;
`endif
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_coord     <= '0;
            r_dat_o     <= '0;
            r_sram_addr <= '0;
            r_sram_din  <= '0;
        end else begin
            if (w_accept && (w_state_nxt == S_WR)) begin
                r_sram_addr <= wbs_adr_i[ADDR_W-1:0];
                r_sram_din  <= wbs_dat_i[16 +: DATA_W];
            end
            if (w_accept && (w_state_nxt == S_RD)) begin
                r_sram_addr <= wbs_adr_i[ADDR_W-1:0];
                r_coord     <= wbs_dat_i[15:0];
            end
            // Counts cycles since the address went out; zero whenever not reading.
            if (r_state == S_RD) begin
                r_cnt <= r_cnt + 3'd1;
            end else begin
                r_cnt <= '0;
            end
            if ((r_state == S_RD) && (w_state_nxt == S_RACK)) begin
                r_dat_o <= {CMD_RD, w_rd_byte, r_coord};
            end
        end
    end

    assign sram_we   = (r_state == S_WR);
    assign sram_addr = r_sram_addr;
    assign sram_din  = r_sram_din;
    assign wbs_ack_o = w_ack;
    assign wbs_dat_o = r_dat_o;
`ifdef WB_SRAM_ERR_EN
    assign wbs_err_o = w_err;
`endif

endmodule

// File: tb/tb_wb_sram_bridge.sv
// tb/tb_wb_sram_bridge.sv - self-checking bench for wb_sram_bridge (table vectors, random traffic, corner sequences)

module tb_wb_sram_bridge;

    localparam int RD_LAT = 2;
    localparam int K_WR   = 0;
    localparam int K_RD   = 1;
    localparam int K_BAD  = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_we_i;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic [8:0]  sram_addr;
    logic [7:0]  sram_din;
    logic [7:0]  sram_dout;
    logic        sram_we;
    logic        err_seen;
    logic        mem_clr;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

`ifdef WB_SRAM_ERR_EN
    logic wbs_err_o;
    assign err_seen = wbs_err_o;
`else
    assign err_seen = 1'b0;
`endif

    wb_sram_bridge #(.RD_LAT(RD_LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .wbs_adr_i (wbs_adr_i),
        .wbs_dat_i (wbs_dat_i),
        .wbs_we_i  (wbs_we_i),
        .wbs_stb_i (wbs_stb_i),
        .wbs_cyc_i (wbs_cyc_i),
        .wbs_ack_o (wbs_ack_o),
        .wbs_dat_o (wbs_dat_o),
        .sram_addr (sram_addr),
        .sram_din  (sram_din),
        .sram_dout (sram_dout),
`ifdef WB_SRAM_ERR_EN
        .sram_we   (sram_we),
        .wbs_err_o (wbs_err_o)
`else
        .sram_we   (sram_we)
`endif
    );

    // SRAM macro model: synchronous write, RD_LAT-cycle registered read.
    logic [7:0] sram_mem [0:511];
    logic [7:0] rd_pipe  [0:RD_LAT-1];

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 512; i++) sram_mem[i] <= 8'h00;
        end else if (sram_we) begin
            sram_mem[sram_addr] <= sram_din;
        end
        rd_pipe[0] <= sram_mem[sram_addr];
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign sram_dout = rd_pipe[RD_LAT-1];

    // Reference model state: expected memory contents and last returned read packet.
    logic [7:0]  model_mem [0:511];
    logic [31:0] exp_dato;

    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
        logic        we;
        int          kind;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    function automatic int model_kind(input logic [31:0] adr, input logic [31:0] dat, input logic we);
        bit adr_ok;
        adr_ok = 1'b1;
`ifdef WB_SRAM_ERR_EN
        adr_ok = (adr[31:9] == 23'd0);
`endif
        if (!adr_ok) return K_BAD;
        if (we && dat[31:24] == 8'hA1) return K_WR;
        if (!we && dat[31:24] == 8'hA2) return K_RD;
        return K_BAD;
    endfunction

    // One Wishbone classic transaction: strobe until ack/err, then release.
    task automatic run_txn(input string nm, input logic [31:0] adr, input logic [31:0] dat,
                           input logic we, input int kind, input logic [31:0] exp_rd);
        int         n;
        int         pulses;
        logic [8:0] p_addr;
        logic [7:0] p_din;
        bit         got_ack;
        bit         got_err;
        int         exp_n;
        n = 0; pulses = 0; got_ack = 0; got_err = 0; p_addr = '0; p_din = '0;
        wbs_adr_i = adr; wbs_dat_i = dat; wbs_we_i = we;
        wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1;
        while (!got_ack && !got_err && n < 20) begin
            @(posedge clk); @(negedge clk);
            n++;
            if (sram_we) begin
                pulses++; p_addr = sram_addr; p_din = sram_din;
            end
            got_ack = wbs_ack_o;
            got_err = err_seen;
        end
        wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0;
        exp_n = (kind == K_RD) ? RD_LAT + 2 : 1;
        chk({nm, " latency"}, n, exp_n);
`ifdef WB_SRAM_ERR_EN
        chk({nm, " ack"}, {31'd0, got_ack}, {31'd0, kind != K_BAD});
        chk({nm, " err"}, {31'd0, got_err}, {31'd0, kind == K_BAD});
`else
        chk({nm, " ack"}, {31'd0, got_ack}, 32'd1);
`endif
        chk({nm, " we pulses"}, pulses, (kind == K_WR) ? 1 : 0);
        if (kind == K_WR) begin
            chk({nm, " sram_addr"}, {23'd0, p_addr}, {23'd0, adr[8:0]});
            chk({nm, " sram_din"}, {24'd0, p_din}, {24'd0, dat[23:16]});
            model_mem[adr[8:0]] = dat[23:16];
        end
        if (kind == K_RD) exp_dato = exp_rd;
        chk({nm, " dat_o"}, wbs_dat_o, exp_dato);
        @(posedge clk); @(negedge clk);
        chk({nm, " idle ack"}, {31'd0, wbs_ack_o}, 32'd0);
        chk({nm, " idle we"}, {31'd0, sram_we}, 32'd0);
    endtask

    initial begin
        logic [31:0] adr;
        logic [31:0] dat;
        logic        we;
        int          kind;
        int          sel;

        for (int i = 0; i < 512; i++) model_mem[i] = 8'h00;
        exp_dato = 32'h0;

        tbl[0]  = '{32'h0000_0005, 32'hA13C_0102, 1'b1, K_WR,  32'h0};
        tbl[1]  = '{32'h0000_0005, 32'hA200_0304, 1'b0, K_RD,  32'hA23C_0304};
        tbl[2]  = '{32'h0000_0007, 32'h5512_3456, 1'b1, K_BAD, 32'h0};
        tbl[3]  = '{32'h0000_01FF, 32'hA17E_0000, 1'b1, K_WR,  32'h0};
        tbl[4]  = '{32'h0000_01FF, 32'hA200_BEEF, 1'b0, K_RD,  32'hA27E_BEEF};
        tbl[5]  = '{32'h0000_0000, 32'hA181_1111, 1'b1, K_WR,  32'h0};
        tbl[6]  = '{32'h0000_0000, 32'hA2FF_2222, 1'b0, K_RD,  32'hA281_2222};
        tbl[7]  = '{32'h0000_0009, 32'hA200_0000, 1'b1, K_BAD, 32'h0};
        tbl[8]  = '{32'h0000_0009, 32'hA100_0000, 1'b0, K_BAD, 32'h0};
`ifdef WB_SRAM_ERR_EN
        tbl[9]  = '{32'h0000_0205, 32'hA199_0001, 1'b1, K_BAD, 32'h0};
        tbl[10] = '{32'h0000_0005, 32'hA200_4444, 1'b0, K_RD,  32'hA23C_4444};
`else
        tbl[9]  = '{32'h0000_0205, 32'hA199_0001, 1'b1, K_WR,  32'h0};
        tbl[10] = '{32'h0000_0005, 32'hA200_4444, 1'b0, K_RD,  32'hA299_4444};
`endif

        // Reset held two cycles with a valid write strobed.
        rst = 1'b1; mem_clr = 1'b1;
        wbs_adr_i = 32'h5; wbs_dat_i = 32'hA13C_0102; wbs_we_i = 1'b1;
        wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); @(negedge clk);
            chk("reset ack", {31'd0, wbs_ack_o}, 32'd0);
            chk("reset we", {31'd0, sram_we}, 32'd0);
            chk("reset dat_o", wbs_dat_o, 32'd0);
            chk("reset sram_addr", {23'd0, sram_addr}, 32'd0);
        end
        wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0;
        rst = 1'b0; mem_clr = 1'b0;
        @(posedge clk); @(negedge clk);

        for (int i = 0; i < 11; i++) begin
            run_txn($sformatf("vec%0d", i), tbl[i].adr, tbl[i].dat, tbl[i].we, tbl[i].kind, tbl[i].exp_rd);
        end

        // Read aborted by dropping cyc one cycle after acceptance.
        wbs_adr_i = 32'h5; wbs_dat_i = 32'hA200_7777; wbs_we_i = 1'b0;
        wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1;
        @(posedge clk); @(negedge clk);
        wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0;
        for (int c = 0; c < RD_LAT + 3; c++) begin
            @(posedge clk); @(negedge clk);
            chk("abort ack", {31'd0, wbs_ack_o}, 32'd0);
            chk("abort dat_o", wbs_dat_o, exp_dato);
        end
        run_txn("post-abort read", 32'h0, 32'hA200_8888, 1'b0, K_RD, {8'hA2, model_mem[0], 16'h8888});

        // cyc dropped right after a write is accepted: pulse still issues, ack suppressed.
        wbs_adr_i = 32'h33; wbs_dat_i = 32'hA15A_0000; wbs_we_i = 1'b1;
        wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1;
        @(posedge clk);
        #1;
        wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0;
        @(negedge clk);
        chk("wr-drop we", {31'd0, sram_we}, 32'd1);
        chk("wr-drop ack", {31'd0, wbs_ack_o}, 32'd0);
        chk("wr-drop addr", {23'd0, sram_addr}, 32'h33);
        model_mem[9'h33] = 8'h5A;
        @(posedge clk); @(negedge clk);
        chk("wr-drop we end", {31'd0, sram_we}, 32'd0);
        run_txn("wr-drop readback", 32'h33, 32'hA200_0033, 1'b0, K_RD, 32'hA25A_0033);

        // Back-to-back writes with stb held: ack on alternate cycles, addresses in order.
        begin
            int k;
            k = 0;
            wbs_adr_i = 32'h10; wbs_dat_i = 32'hA120_0000; wbs_we_i = 1'b1;
            wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1;
            for (int c = 0; c < 8; c++) begin
                @(posedge clk); @(negedge clk);
                chk($sformatf("b2b ack c%0d", c), {31'd0, wbs_ack_o}, {31'd0, (c % 2) == 0});
                chk($sformatf("b2b we c%0d", c), {31'd0, sram_we}, {31'd0, (c % 2) == 0});
                if ((c % 2) == 0) begin
                    chk($sformatf("b2b addr%0d", k), {23'd0, sram_addr}, 32'h10 + k);
                    model_mem[9'h10 + k] = 8'h20 + 8'(k);
                    k++;
                    if (k < 4) begin
                        wbs_adr_i = 32'h10 + k;
                        wbs_dat_i = {8'hA1, 8'h20 + 8'(k), 16'h0};
                    end else begin
                        wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0;
                    end
                end
            end
            run_txn("b2b readback", 32'h12, 32'hA200_0012, 1'b0, K_RD, 32'hA222_0012);
        end

        // Randomised traffic against the reference model.
        for (int t = 0; t < 40; t++) begin
            adr = {23'd0, 9'($urandom_range(0, 511))};
            if ($urandom_range(0, 7) == 0) adr[12] = 1'b1;
            sel = $urandom_range(0, 7);
            dat = $urandom;
            if (sel < 3)      dat[31:24] = 8'hA1;
            else if (sel < 6) dat[31:24] = 8'hA2;
            else if (sel == 7) dat[31:24] = 8'h55;
            we = (dat[31:24] == 8'hA1);
            if ($urandom_range(0, 5) == 0) we = ~we;
            kind = model_kind(adr, dat, we);
            run_txn($sformatf("rand%0d", t), adr, dat, we, kind, {8'hA2, model_mem[adr[8:0]], dat[15:0]});
        end

        // Reset in the middle of a read.
        wbs_adr_i = 32'h5; wbs_dat_i = 32'hA200_9999; wbs_we_i = 1'b0;
        wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1;
        @(posedge clk); @(negedge clk);
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("midrst ack", {31'd0, wbs_ack_o}, 32'd0);
        chk("midrst we", {31'd0, sram_we}, 32'd0);
        chk("midrst dat_o", wbs_dat_o, 32'd0);
        chk("midrst addr", {23'd0, sram_addr}, 32'd0);
        rst = 1'b0; wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0;
        exp_dato = 32'h0;
        for (int c = 0; c < RD_LAT + 2; c++) begin
            @(posedge clk); @(negedge clk);
            chk("midrst no ack", {31'd0, wbs_ack_o}, 32'd0);
        end
        run_txn("post-rst read", 32'h1FF, 32'hA200_ABCD, 1'b0, K_RD, {8'hA2, model_mem[9'h1FF], 16'hABCD});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
